// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory subsystem for a single-cycle MIPS core.
// Word-addressed RAM, LED register, free-running cycle counter and an
// 8-bit transmit FIFO. Loads are combinational and have no side effects.
// Stores take effect at the rising clock edge where memwrite is high.
//
// Ports:
//   clk        system clock (rising edge)
//   reset      asynchronous active-low reset
//   memwrite   store strobe from core
//   addr       byte address (addr[1:0] ignored)
//   writedata  store data
//   readdata   load data, combinational
//   led        LED register contents
//   tx_data    FIFO head byte, 0 when empty
//   tx_valid   FIFO non-empty
//   tx_ready   consumer takes head byte this cycle
module dmem_mmio #(
    parameter int RAM_WORDS  = 64,
    parameter int LED_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [31:0]      addr,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [LED_W-1:0] led,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam int AW  = $clog2(RAM_WORDS);
    localparam int FPW = $clog2(FIFO_DEPTH);

    localparam logic [FPW:0]   CNT_ONE  = 1;
    localparam logic [FPW:0]   CNT_FULL = FIFO_DEPTH;
    localparam logic [FPW-1:0] PTR_ONE  = 1;
    localparam logic [31:0]    RAM_END  = 32'(4 * RAM_WORDS);

    // ---------------- address decode ----------------
    // Byte-lane bits are masked off here so every later compare works on
    // a word-aligned address.
    logic [31:0] w_waddr;
    logic        w_ram_sel, w_io_sel;
    logic        w_led_sel, w_cyc_sel, w_txd_sel, w_txs_sel;

    assign w_waddr   = addr & 32'hFFFF_FFFC;
    assign w_ram_sel = (w_waddr < RAM_END);
    assign w_io_sel  = ((w_waddr & 32'hFFFF_FFF0) == 32'hFFFF_0000);
    assign w_led_sel = w_io_sel && (w_waddr[3:2] == 2'd0);
    assign w_cyc_sel = w_io_sel && (w_waddr[3:2] == 2'd1);
    assign w_txd_sel = w_io_sel && (w_waddr[3:2] == 2'd2);
    assign w_txs_sel = w_io_sel && (w_waddr[3:2] == 2'd3);

    // ---------------- state ----------------
    logic [31:0]      r_ram [RAM_WORDS];
    logic [LED_W-1:0] r_led;
    logic [31:0]      r_cycle;
    logic [7:0]       r_fifo [FIFO_DEPTH];
    logic [FPW-1:0]   r_rd_ptr, r_wr_ptr;
    logic [FPW:0]     r_count;
    logic             r_ovf;

    // ---------------- FIFO control ----------------
    logic w_full, w_empty, w_push_req, w_push, w_pop, w_drop;

    assign w_full     = (r_count == CNT_FULL);
    assign w_empty    = (r_count == '0);
    assign w_push_req = memwrite && w_txd_sel;
    // Fullness is judged before any same-cycle pop: a push that meets a
    // full FIFO is dropped even if the head leaves on the same edge.
    assign w_push     = w_push_req && !w_full;
    assign w_drop     = w_push_req && w_full;
    assign w_pop      = tx_valid && tx_ready;

    assign tx_valid = !w_empty;
    assign tx_data  = tx_valid ? r_fifo[r_rd_ptr] : 8'h00;
    assign led      = r_led;

    // RAM has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (memwrite && w_ram_sel)
            r_ram[w_waddr[AW+1:2]] <= writedata;
    end

    // FIFO storage carries no reset; tx_data is gated by tx_valid.
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= writedata[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led    <= '0;
            r_cycle  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (memwrite && w_led_sel)
                r_led <= writedata[LED_W-1:0];

            // A store replaces this edge's increment.
            if (memwrite && w_cyc_sel)
                r_cycle <= writedata;
            else
                r_cycle <= r_cycle + 32'd1;

            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase

            // Setting by a dropped push beats a clearing status write.
            if (w_drop)
                r_ovf <= 1'b1;
            else if (memwrite && w_txs_sel)
                r_ovf <= 1'b0;
        end
    end

    // ---------------- load path ----------------
    always_comb begin
        readdata = 32'h0;
        if (w_ram_sel)
            readdata = r_ram[w_waddr[AW+1:2]];
        else if (w_led_sel)
            readdata = 32'(r_led);
        else if (w_cyc_sel)
            readdata = r_cycle;
        else if (w_txs_sel)
            readdata = {23'h0, 5'(r_count), 1'b0, r_ovf, w_empty, w_full};
    end

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

    localparam logic [31:0] A_LED = 32'hFFFF_0000;
    localparam logic [31:0] A_CYC = 32'hFFFF_0004;
    localparam logic [31:0] A_TXD = 32'hFFFF_0008;
    localparam logic [31:0] A_TXS = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int total = 0;
    int bad   = 0;

    dmem_mmio #(.RAM_WORDS(64), .LED_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
        .writedata(writedata), .readdata(readdata), .led(led),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    // Called at a falling edge: store commits at the next rising edge,
    // returns at the following falling edge with memwrite low.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; addr = a; writedata = d;
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        memwrite = 1'b0; addr = a;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; memwrite = 1'b0; addr = '0; writedata = '0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (led !== 8'h00) begin bad++; $display("FAIL rst_led act=%h exp=00", led); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid act=%b exp=0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_txdata act=%h exp=00", tx_data); end
        do_read(A_TXS);
        total++; if (readdata !== 32'h2) begin bad++; $display("FAIL rst_txstat act=%h exp=00000002", readdata); end
        @(negedge clk);
        reset = 1'b1;
        do_read(A_CYC);
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL rst_cyc0 act=%h exp=00000000", readdata); end
        @(negedge clk);
        do_read(A_CYC);
        total++; if (readdata !== 32'h1) begin bad++; $display("FAIL rst_cyc1 act=%h exp=00000001", readdata); end
        @(negedge clk);
    endtask

    task automatic test_ram;
        do_write(32'h0000_0010, 32'hDEAD_BEEF);
        do_read(32'h0000_0010);
        total++; if (readdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_wr_rd act=%h exp=deadbeef", readdata); end
        do_write(32'h0000_00FC, 32'h1234_5678);
        do_read(32'h0000_00FE);
        total++; if (readdata !== 32'h1234_5678) begin bad++; $display("FAIL ram_top act=%h exp=12345678", readdata); end
        do_read(32'h0000_0010);
        total++; if (readdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_keep act=%h exp=deadbeef", readdata); end
        do_write(32'h0000_0100, 32'hCAFE_F00D);
        do_read(32'h0000_0100);
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL ram_oob act=%h exp=00000000", readdata); end
        do_read(32'h0000_0000);
        total++; if (readdata === 32'hCAFE_F00D) begin bad++; $display("FAIL ram_alias act=%h exp=not cafef00d", readdata); end
        do_read(A_TXD);
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL txd_read act=%h exp=00000000", readdata); end
        do_read(32'hFFFF_0010);
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL unmapped act=%h exp=00000000", readdata); end
    endtask

    task automatic test_led;
        do_write(A_LED, 32'h0000_01A5);
        total++; if (led !== 8'hA5) begin bad++; $display("FAIL led_out act=%h exp=a5", led); end
        do_read(A_LED);
        total++; if (readdata !== 32'h0000_00A5) begin bad++; $display("FAIL led_read act=%h exp=000000a5", readdata); end
        #2 reset = 1'b0;
        #1;
        total++; if (led !== 8'h00) begin bad++; $display("FAIL led_async_rst act=%h exp=00", led); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_cycle;
        do_write(A_CYC, 32'hFFFF_FFFE);
        do_read(A_CYC);
        total++; if (readdata !== 32'hFFFF_FFFE) begin bad++; $display("FAIL cyc_load act=%h exp=fffffffe", readdata); end
        @(negedge clk); do_read(A_CYC);
        total++; if (readdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cyc_inc act=%h exp=ffffffff", readdata); end
        @(negedge clk); do_read(A_CYC);
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL cyc_wrap act=%h exp=00000000", readdata); end
        @(negedge clk); do_read(A_CYC);
        total++; if (readdata !== 32'h1) begin bad++; $display("FAIL cyc_after act=%h exp=00000001", readdata); end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_write(A_TXD, {24'h0, exp_b[i]});
        do_read(A_TXS);
        total++; if (readdata !== 32'h41) begin bad++; $display("FAIL ovf_full act=%h exp=00000041", readdata); end
        do_write(A_TXD, 32'h55);
        do_read(A_TXS);
        total++; if (readdata !== 32'h45) begin bad++; $display("FAIL ovf_set act=%h exp=00000045", readdata); end
        @(negedge clk); #1;
        total++; if (tx_data !== 8'h11 || tx_valid !== 1'b1) begin bad++; $display("FAIL ovf_stable act=%h/%b exp=11/1", tx_data, tx_valid); end
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (tx_data !== exp_b[i] || tx_valid !== 1'b1) begin bad++; $display("FAIL ovf_drain%0d act=%h/%b exp=%h/1", i, tx_data, tx_valid, exp_b[i]); end
            @(negedge clk);
        end
        do_read(A_TXS);
        total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("FAIL ovf_empty act=%h/%b exp=00/0", tx_data, tx_valid); end
        total++; if (readdata !== 32'h6) begin bad++; $display("FAIL ovf_stat act=%h exp=00000006", readdata); end
        tx_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        do_write(A_TXD, 32'hA1);
        do_write(A_TXD, 32'hA2);
        tx_ready = 1'b1;
        memwrite = 1'b1; addr = A_TXD; writedata = 32'h77;
        #1;
        total++; if (tx_data !== 8'hA1) begin bad++; $display("FAIL b2b_head act=%h exp=a1", tx_data); end
        @(negedge clk);
        do_read(A_TXS);
        total++; if (readdata !== 32'h24) begin bad++; $display("FAIL b2b_count act=%h exp=00000024", readdata); end
        total++; if (tx_data !== 8'hA2) begin bad++; $display("FAIL b2b_second act=%h exp=a2", tx_data); end
        @(negedge clk); #1;
        total++; if (tx_data !== 8'h77) begin bad++; $display("FAIL b2b_last act=%h exp=77", tx_data); end
        @(negedge clk); #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty act=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_full_push_pop;
        do_write(A_TXS, 32'hFFFF_FFFF);
        do_read(A_TXS);
        total++; if (readdata !== 32'h2) begin bad++; $display("FAIL clr_ovf act=%h exp=00000002", readdata); end
        for (int i = 0; i < 4; i++) do_write(A_TXD, 32'hB1 + i);
        do_read(A_TXS);
        total++; if (readdata !== 32'h41) begin bad++; $display("FAIL fpp_full act=%h exp=00000041", readdata); end
        tx_ready = 1'b1;
        do_write(A_TXD, 32'hB5);
        tx_ready = 1'b0;
        do_read(A_TXS);
        total++; if (readdata !== 32'h34) begin bad++; $display("FAIL fpp_drop act=%h exp=00000034", readdata); end
        total++; if (tx_data !== 8'hB2) begin bad++; $display("FAIL fpp_head act=%h exp=b2", tx_data); end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (tx_data !== 8'hB2 + 8'(i)) begin bad++; $display("FAIL fpp_drain%0d act=%h exp=%h", i, tx_data, 8'hB2 + 8'(i)); end
            @(negedge clk);
        end
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL fpp_nob5 act=%b/%h exp=0/00", tx_valid, tx_data); end
        tx_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_ram;
        test_led;
        test_cycle;
        test_overflow;
        test_back_to_back;
        test_full_push_pop;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
Data-side memory subsystem driven directly by the single-cycle MIPS core's memwrite/aluout/writedata and returning readdata in the same cycle. Decodes the byte address into three regions:
- word-addressed data RAM
- LED output register and free-running cycle counter
- 8-bit transmit FIFO drained by a downstream valid/ready consumer (UART or host link)

Parameters:
RAM_WORDS, 64, number of 32-bit RAM words; power of 2, 4..1024
LED_W, 8, width of LED register, 1..32
FIFO_DEPTH, 4, TX FIFO entries; power of 2, 2..16

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-low reset (0 = reset asserted)
memwrite  input  1  store strobe from core, sampled at rising clk
addr  input  32  byte address (core aluout)
writedata  input  32  store data from core
readdata  output  32  load data, combinational from addr and current state
led  output  LED_W  LED register contents
tx_data  output  8  FIFO head byte; 0 when empty
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  consumer accepts head byte this cycle

Behaviour:
- Address map (addr[1:0] ignored; word accesses only):
  - RAM: addr < 4*RAM_WORDS, index addr[log2(RAM_WORDS)+1:2], RW.
  - 0xFFFF0000: LED, RW. Write loads writedata[LED_W-1:0]. Read zero-extends.
  - 0xFFFF0004: CYCLE, RW.
  - 0xFFFF0008: TXDATA, write-only. Read returns 0.
  - 0xFFFF000C: TXSTAT. Read: bit0 full, bit1 empty, bit2 overflow (sticky), bits[8:4] count, others 0. Any write clears overflow.
  - All other addresses: read 0; writes ignored, no state change.
- Reads are purely combinational, zero latency, with no side effects.
- Writes take effect at the rising clk edge where memwrite=1. The new value is visible on readdata the following cycle.
- RAM:
  - Not reset; contents undefined until written.
  - Write-then-read of the same word in consecutive cycles returns the new data.
- CYCLE:
  - Increments by 1 every clock; wraps 0xFFFFFFFF -> 0x00000000.
  - A write loads writedata and takes priority over the increment that cycle. The next cycle reads writedata+1.
- TX FIFO:
  - Circular buffer with read/write pointers and a count register (0..FIFO_DEPTH).
  - Push on memwrite to TXDATA: writedata[7:0] enters the tail if count < FIFO_DEPTH at that edge.
  - Push when full is dropped and sets overflow=1. A dropped push still counts as full even if a pop occurs the same cycle.
  - Pop when tx_valid && tx_ready: head advances, count decrements.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
  - tx_valid = (count != 0). tx_data = mem[rd_ptr] when valid, else 0.
  - tx_data/tx_valid are stable while tx_valid=1 and tx_ready=0.
  - Pointers wrap modulo FIFO_DEPTH.
- TXSTAT write that clears overflow in the same cycle a full-drop sets it: set wins (overflow=1).
- Reset (reset=0, asynchronous, any time including mid-transfer):
  - led=0, CYCLE=0, FIFO pointers and count=0, overflow=0, so tx_valid=0 and tx_data=0.
  - RAM unaffected.
  - After reset deasserts, CYCLE reads 0 in the first cycle, then counts.

Test Plan:
- Reset, then store 0xDEADBEEF to 0x0000_0010 and 0x12345678 to 0x0000_00FC; load both -> readdata 0xDEADBEEF, 0x12345678. Load 0x0000_0100 -> 0 (out of range for RAM_WORDS=64).
- Store 0x000001A5 to 0xFFFF0000 -> led=0xA5. Load 0xFFFF0000 -> 0x000000A5. Assert reset mid-run -> led=0 immediately, without a clock.
- Store 0xFFFFFFFE to CYCLE -> following cycles read 0xFFFFFFFF, 0x00000000, 0x00000001.
- Hold tx_ready=0; push 0x11,0x22,0x33,0x44,0x55:
  - TXSTAT reads 0x00000041 after 4 pushes (full, count=4).
  - After 5th push, TXSTAT reads 0x00000045 (overflow set).
  - Raise tx_ready -> tx_data 0x11,0x22,0x33,0x44 on successive cycles, then tx_valid=0, TXSTAT=0x00000006.
- With count=2 and tx_ready=1, push 0x77 in the same cycle as a pop -> count stays 2, byte order preserved, 0x77 emerges last.
- Write TXSTAT -> overflow clears (bit2=0). Push on a full FIFO while simultaneously popping -> byte dropped, overflow=1, count=3.
